// File: rtl/ro_bit_collector.sv
// ro_bit_collector: ring-oscillator sampler for the TRNG datapath.
// Holds or releases the RO, synchronizes and strobes its output, runs a sticky
// repetition-count health check on raw samples and packs accepted bits into
// WIDTH-bit words offered on a valid/ready port.
// Optional feature: define VON_NEUMANN_EN to debias sample pairs before packing.
module ro_bit_collector #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_DIV    = 4,
    parameter int WARMUP_CYCLES = 16,
    parameter int REP_LIMIT     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ro_signal,
    output logic             ro_stop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);
    localparam int CNT_W  = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_TRIP  = RUN_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        STALL
    } state_t;

    state_t state, state_next;

    logic              sync_meta;
    logic              sample;
    logic              prev_sample;
    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic [WIDTH-1:0]  shifter;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WIDTH-1:0]  new_word;
    logic [WIDTH-1:0]  load_data;
    logic              active;
    logic              out_free;
    logic              strobe;
    logic              trip;
    logic              bit_take;
    logic              bit_val;
    logic              word_done;
    logic              load_new;
    logic              load_stall;
    logic              load;

`ifdef VON_NEUMANN_EN
    logic pair_valid;
    logic pair_first;
`endif

    // Two-flop synchronizer for the free-running RO output; no reset because
    // its contents only matter once strobes begin, long after warm-up.
    always_ff @(posedge clock) begin
        sync_meta <= ro_signal;
        sample    <= sync_meta;
    end

    // Strobe generation, health-count lookahead and bit/word acceptance decode.
    always_comb begin
        active   = enable && !health_fail;
        out_free = !out_valid || out_ready;
        strobe   = (state == RUN) && active && (div_cnt == DIV_LAST);

        if (run_cnt == '0 || sample != prev_sample) begin
            run_next = RUN_W'(1);
        end else begin
            run_next = run_cnt + RUN_W'(1);
        end
        trip = strobe && (run_next == RUN_TRIP);

`ifdef VON_NEUMANN_EN
        bit_take = strobe && !trip && pair_valid && (pair_first != sample);
        bit_val  = pair_first;
`else
        bit_take = strobe && !trip;
        bit_val  = sample;
`endif

        new_word   = {shifter[WIDTH-2:0], bit_val};
        word_done  = bit_take && (bit_cnt == CNT_LAST);
        load_new   = word_done && out_free;
        load_stall = (state == STALL) && active && out_free;
        load       = load_new || load_stall;
        load_data  = load_stall ? shifter : new_word;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and RO halt control; losing enable or health always wins.
    always_comb begin
        state_next = state;
        ro_stop    = 1'b0;
        case (state)
            IDLE: begin
                ro_stop = 1'b1;
                if (active) begin
                    state_next = WARMUP;
                end
            end
            WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (word_done && !out_free) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (out_free) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!active || trip) begin
            state_next = IDLE;
        end
    end

    // Warm-up timer and sample divider; the divider keeps turning while stalled
    // so sampling resumes on its regular cadence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warm_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end else begin
                warm_cnt <= '0;
            end
            if (state == RUN || state == STALL) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
            end
        end
    end

    // Repetition-count health check on every raw strobed sample; failure is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt     <= '0;
            prev_sample <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (state == IDLE) begin
                run_cnt <= '0;
            end else if (strobe) begin
                run_cnt     <= run_next;
                prev_sample <= sample;
            end
            if (trip) begin
                health_fail <= 1'b1;
            end
        end
    end

`ifdef VON_NEUMANN_EN
    // Pair tracker for the Von Neumann debiaser; forgotten whenever sampling pauses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_valid <= 1'b0;
            pair_first <= 1'b0;
        end else if (state != RUN || trip) begin
            pair_valid <= 1'b0;
        end else if (strobe) begin
            if (!pair_valid) begin
                pair_first <= sample;
                pair_valid <= 1'b1;
            end else begin
                pair_valid <= 1'b0;
            end
        end
    end
`endif

    // Bit packer: newest bit enters at the LSB; a full word that cannot be
    // handed off parks here (bit_cnt == WIDTH) until the output register frees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shifter <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE || load_stall) begin
            shifter <= '0;
            bit_cnt <= '0;
        end else if (bit_take) begin
            if (word_done) begin
                shifter <= out_free ? '0 : new_word;
                bit_cnt <= out_free ? '0 : CNT_FULL;
            end else begin
                shifter <= new_word;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Output holding register; survives enable drop and health failure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_bit_collector.sv
// tb_ro_bit_collector: directed bench for ro_bit_collector with a word scoreboard.
// Honours VON_NEUMANN_EN the same way the design does.
module tb_ro_bit_collector;

    localparam int WIDTH         = 8;
    localparam int SAMPLE_DIV    = 4;
    localparam int WARMUP_CYCLES = 16;
    localparam int REP_LIMIT     = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             ro_signal;
    logic             ro_stop;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             health_fail;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] expected_q[$];
    int               edges_to_strobe = SAMPLE_DIV;

    ro_bit_collector #(
        .WIDTH(WIDTH),
        .SAMPLE_DIV(SAMPLE_DIV),
        .WARMUP_CYCLES(WARMUP_CYCLES),
        .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .ro_signal(ro_signal),
        .ro_stop(ro_stop),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .health_fail(health_fail)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Global time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Hold one raw RO level across the next sample strobe; returns 1 ns after that strobe's edge.
    task automatic apply_stimulus(input logic v);
        ro_signal = v;
        repeat (edges_to_strobe) @(posedge clock);
        #1;
        edges_to_strobe = SAMPLE_DIV;
    endtask

    task automatic send_bit(input logic b);
`ifdef VON_NEUMANN_EN
        apply_stimulus(b);
        apply_stimulus(~b);
`else
        apply_stimulus(b);
`endif
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        expected_q.push_back(w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    // First strobe lands WARMUP_CYCLES + SAMPLE_DIV edges after the enable edge.
    task automatic start_run();
        @(negedge clock);
        enable = 1'b1;
        edges_to_strobe = WARMUP_CYCLES + SAMPLE_DIV + 1;
    endtask

    task automatic stop_run(input string name);
        @(negedge clock);
        enable = 1'b0;
        @(posedge clock);
        #1;
        check_output(name, ro_stop, 1);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected word.
    initial begin
        logic [WIDTH-1:0] exp_word;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (expected_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL word_unexpected: got 0x%0h expected none", out_data);
                end else begin
                    exp_word = expected_q.pop_front();
                    if (out_data !== exp_word) begin
                        errors++;
                        $display("[TB] FAIL word_data: got 0x%0h expected 0x%0h", out_data, exp_word);
                    end
                end
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        ro_signal = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_ro_stop", ro_stop, 1);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_out_data", out_data, 0);
        check_output("reset_health_fail", health_fail, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_output("idle_ro_stop", ro_stop, 1);

`ifndef VON_NEUMANN_EN
        $display("[TB] raw pattern 1,0,1,1,0,0,1,0");
        start_run();
        expected_q.push_back(8'hB2);
        apply_stimulus(1'b1);
        check_output("ro_stop_running", ro_stop, 0);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        check_output("word_valid", out_valid, 1);
        stop_run("ro_stop_after_disable");
`else
        $display("[TB] debias pairs 01,10,11,00,10");
        start_run();
        expected_q.push_back(8'h74);
        apply_stimulus(1'b0);
        check_output("ro_stop_running", ro_stop, 0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check_output("word_valid", out_valid, 1);
        stop_run("ro_stop_after_disable");
`endif

        $display("[TB] backpressure across two words");
        @(negedge clock);
        out_ready = 1'b0;
        start_run();
        send_word(8'h5A);
        send_word(8'hC3);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        check_output("stall_valid", out_valid, 1);
        check_output("stall_data_held", out_data, 8'h5A);
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        check_output("valid_after_transfer_load", out_valid, 1);
        @(negedge clock);
        check_output("valid_drop_after_last", out_valid, 0);
        stop_run("ro_stop_backpressure");

        $display("[TB] enable drop mid-word with pending output");
        @(negedge clock);
        out_ready = 1'b0;
        start_run();
        send_word(8'h96);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        stop_run("ro_stop_mid_word");
        repeat (10) @(negedge clock);
        check_output("pending_valid_kept", out_valid, 1);
        check_output("pending_data_kept", out_data, 8'h96);
        out_ready = 1'b1;
        start_run();
        send_word(8'h3C);
        stop_run("ro_stop_after_restart");

        $display("[TB] reset mid-run with partial word");
        @(negedge clock);
        out_ready = 1'b0;
        start_run();
        send_word(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        check_output("pre_reset_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("midrun_reset_ro_stop", ro_stop, 1);
        check_output("midrun_reset_out_valid", out_valid, 0);
        check_output("midrun_reset_out_data", out_data, 0);
        check_output("midrun_reset_health", health_fail, 0);
        expected_q.delete();
        enable    = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] stuck-at-1 repetition check");
        start_run();
`ifndef VON_NEUMANN_EN
        for (int i = 0; i < 3; i++) begin
            expected_q.push_back(8'hFF);
        end
`endif
        for (int i = 0; i < REP_LIMIT - 1; i++) begin
            apply_stimulus(1'b1);
        end
        check_output("health_before_limit", health_fail, 0);
        apply_stimulus(1'b1);
        check_output("health_at_limit", health_fail, 1);
        check_output("ro_stop_at_limit", ro_stop, 1);
        @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);
        enable = 1'b1;
        repeat (30) @(negedge clock);
        check_output("health_sticky", health_fail, 1);
        check_output("ro_stop_held_after_fail", ro_stop, 1);
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_output("health_cleared_by_reset", health_fail, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        check_output("scoreboard_drained", expected_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
